pr_axi_rd_arb: RTL
==================

Name: pr_axi_rd_arb

Overview:
- Shares the single AXI read master port (AR + R channels) of the PageRank accelerator between N_REQ internal read engines: vertex reader, in-edge reader and rank reader.
- Arbitrates AR requests round-robin and tags ARID with the requester index.
- Routes R beats back to the owning requester by RID.
- Caps outstanding bursts per requester so one engine cannot starve the others.

Parameters:
N_REQ, 3, number of requesters (2..8)
IDX_W, 2, bits of requester index carried in arid_m (ceil(log2(N_REQ)), at least 1)
MAX_OUT, 4, maximum outstanding bursts per requester (1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_araddr  in  N_REQ*64  packed per-requester byte addresses; requester i at [64*i +: 64]
req_arlen  in  N_REQ*8  packed burst lengths (beats-1)
req_arvalid  in  N_REQ  request valid per requester
req_arready  out  N_REQ  one-hot accept pulse
req_rdata  out  512  rdata_m broadcast to all requesters
req_rlast  out  1  rlast_m broadcast
req_rvalid  out  N_REQ  one-hot beat valid
req_rready  in  N_REQ  per-requester beat ready
arid_m  out  16  AXI ARID
araddr_m  out  64  AXI ARADDR
arlen_m  out  8  AXI ARLEN
arsize_m  out  3  AXI ARSIZE, constant 3'b110 (64 B beats)
arvalid_m  out  1  AXI ARVALID
arready_m  in  1  AXI ARREADY
rid_m  in  16  AXI RID
rdata_m  in  512  AXI RDATA
rresp_m  in  2  AXI RRESP
rlast_m  in  1  AXI RLAST
rvalid_m  in  1  AXI RVALID
rready_m  out  1  AXI RREADY
busy  out  1  high when arvalid_m is asserted or any outstanding count is nonzero
err  out  1  sticky error flag; cleared only by rst

Behaviour:
Reset values:
- arvalid_m=0, req_arready=0, arid_m/araddr_m/arlen_m=0, err=0.
- Round-robin pointer=0; all outstanding counters=0.

AR FSM has two states, IDLE and ISSUE.
- IDLE:
  - Eligible requesters: req_arvalid[i]=1 and out_cnt[i]<MAX_OUT.
  - Winner: first eligible index at or after rr_ptr, wrapping modulo N_REQ.
  - In the cycle a winner exists: pulse req_arready[winner]=1 (accept), register addr/len into the output stage, set arid_m={zeros, winner[IDX_W-1:0]}, set rr_ptr=(winner+1) mod N_REQ, go to ISSUE.
  - No eligible requester: stay in IDLE; rr_ptr unchanged.
- ISSUE:
  - arvalid_m=1 with fields held stable.
  - On arready_m=1, go to IDLE next cycle.
  - Minimum spacing between AR handshakes is 2 cycles.
- Latency: arvalid_m rises exactly 1 cycle after req_arready pulses.
- req_arready is combinational from the IDLE state and the arbitration result, and is never high in ISSUE.

Outstanding counters (4 bits per requester):
- Increment on accept (req_arready[i]).
- Decrement on R handshake (rvalid_m && rready_m && rlast_m) with rid_m[IDX_W-1:0]==i.
- Increment and decrement in the same cycle: net unchanged.
- Counter at MAX_OUT: requester is masked from arbitration.
- Decrement with counter already 0 (unexpected RID): counter holds at 0 and err is set.

R routing (purely combinational, zero latency):
- idx=rid_m[IDX_W-1:0]; req_rvalid[i]=rvalid_m && (idx==i).
- rready_m=req_rready[idx].
- idx>=N_REQ or rid_m[15:IDX_W]!=0: rready_m=1 (beat drained and dropped), no req_rvalid asserted, err set.
- Handshake with rresp_m!=0: err set; the beat is still delivered.

Reset mid-operation: all state cleared in one cycle. In-flight bursts are abandoned; the surrounding top-level resets the memory side together with this block.

Decomposition:
- Shared package pr_constants: ARSIZE_64B=3'b110, AXI width constants (ID 16, ADDR 64, DATA 512), default MAX_OUT.
- Sub-module pr_rr_arbiter (N-way round-robin pick: request vector + pointer in, one-hot grant + index out). It is reused later for the AXI write arbiter.

Test Plan:
- Single requester: requester 1 issues araddr=0x3E80, arlen=3 → req_arready[1] at cycle T, arvalid_m at T+1 with arid_m=1; 4 beats returned with rid_m=1 → req_rvalid[1] on all 4, out_cnt[1] returns 0, busy drops.
- Fairness: all 3 requesters hold req_arvalid for 9 grants with arready_m=1 → grant order 0,1,2,0,1,2,0,1,2.
- Backpressure: hold arready_m=0 for 5 cycles → arvalid_m and fields stay stable, no req_arready pulses; grant resumes 1 cycle after the handshake.
- Cap: requester 0 issues 4 bursts, memory withholds R → 5th request not accepted while requester 2 is still granted; the first rlast to rid 0 re-enables requester 0.
- Interleaved R with backpressure: beats alternate rid 0/2 while req_rready[2]=0 → rready_m=0 on rid-2 beats only; data is delivered to the matching requester.
- Errors: rid_m=3 beat → rready_m=1, no req_rvalid, err=1 and stays 1 until rst; a separate run with rresp_m=2 → err=1.

Source files
------------

// File: rtl/pr_constants.sv
// Shared constants for the PageRank accelerator AXI glue.
// Holds the AXI field widths used on the memory master port, the fixed
// 64-byte beat size, the default per-requester outstanding-burst cap, and
// the AR-side arbitration state type shared by the read (and later write)
// arbiters.
package pr_constants;

  localparam int AXI_ID_W    = 16;
  localparam int AXI_ADDR_W  = 64;
  localparam int AXI_DATA_W  = 512;
  localparam int AXI_LEN_W   = 8;
  localparam int DEF_MAX_OUT = 4;
  localparam int CNT_W       = 4;

  // 2^6 = 64 bytes per beat, matching the 512-bit data bus
  localparam logic [2:0] ARSIZE_64B = 3'b110;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_t;

endpackage

// File: rtl/pr_rr_arbiter.sv
// N-way round-robin picker.
// Ports:
//   req         - request vector, one bit per requester
//   ptr         - highest-priority index for this pick
//   grant       - one-hot grant, all zero when nothing requests
//   grant_idx   - binary index of the granted requester
//   grant_valid - high when any requester was granted
// Purely combinational; the caller owns the pointer register and decides
// how to advance it.
module pr_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Walk the requesters starting at ptr and wrapping modulo N; the first
  // active one wins.
  always_comb begin
    int j;
    j           = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant[j]    = 1'b1;
        grant_idx   = IDX_W'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pr_axi_rd_arb.sv
// Shares the accelerator's single AXI read master port among N_REQ read
// engines (vertex, in-edge and rank readers).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_ar* / req_arready    - per-requester packed AR requests, one-hot accept
//   req_r* / req_rready      - R beats routed back by RID, per-requester ready
//   ar*_m / r*_m             - AXI master AR and R channels
//   busy                     - AR pending or any burst still outstanding
//   err                      - sticky: bad RID, non-OKAY RRESP or counter underflow
// ARs are granted round-robin with the requester index carried in ARID.
// Each requester may have at most MAX_OUT bursts in flight.
module pr_axi_rd_arb
  import pr_constants::*;
#(
  parameter int N_REQ   = 3,
  parameter int IDX_W   = 2,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ*AXI_ADDR_W-1:0] req_araddr,
  input  logic [N_REQ*AXI_LEN_W-1:0]  req_arlen,
  input  logic [N_REQ-1:0]            req_arvalid,
  output logic [N_REQ-1:0]            req_arready,
  output logic [AXI_DATA_W-1:0]       req_rdata,
  output logic                        req_rlast,
  output logic [N_REQ-1:0]            req_rvalid,
  input  logic [N_REQ-1:0]            req_rready,
  output logic [AXI_ID_W-1:0]         arid_m,
  output logic [AXI_ADDR_W-1:0]       araddr_m,
  output logic [AXI_LEN_W-1:0]        arlen_m,
  output logic [2:0]                  arsize_m,
  output logic                        arvalid_m,
  input  logic                        arready_m,
  input  logic [AXI_ID_W-1:0]         rid_m,
  input  logic [AXI_DATA_W-1:0]       rdata_m,
  input  logic [1:0]                  rresp_m,
  input  logic                        rlast_m,
  input  logic                        rvalid_m,
  output logic                        rready_m,
  output logic                        busy,
  output logic                        err
);

  ar_state_t          state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   out_cnt [N_REQ];
  logic [N_REQ-1:0]   eligible, grant, cnt_inc, cnt_dec;
  logic [IDX_W-1:0]   grant_idx, r_idx;
  logic               grant_valid, accept, bad_rid, r_hs, r_done, underflow;

  // A requester at its outstanding cap sits out arbitration until a burst
  // of its own completes.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_arvalid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
  end

  pr_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign accept      = (state == AR_IDLE) && grant_valid;
  assign req_arready = accept ? grant : '0;
  assign arvalid_m   = (state == AR_ISSUE);
  assign arsize_m    = ARSIZE_64B;

  // Accept in IDLE, then present the registered AR until the slave takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE:  if (grant_valid) state_nxt = AR_ISSUE;
      AR_ISSUE: if (arready_m)   state_nxt = AR_IDLE;
      default:  state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= AR_IDLE;
    else     state <= state_nxt;
  end

  // The output stage is loaded only on accept, so the AR fields stay frozen
  // for the whole ISSUE phase however long the slave stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      arid_m   <= '0;
      araddr_m <= '0;
      arlen_m  <= '0;
    end else if (accept) begin
      araddr_m <= req_araddr[AXI_ADDR_W*grant_idx +: AXI_ADDR_W];
      arlen_m  <= req_arlen[AXI_LEN_W*grant_idx +: AXI_LEN_W];
      arid_m   <= {{(AXI_ID_W-IDX_W){1'b0}}, grant_idx};
      rr_ptr   <= (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // R routing: an RID that names no requester is drained (rready_m=1) so the
  // interconnect can never lock up on it.
  assign r_idx   = rid_m[IDX_W-1:0];
  assign bad_rid = (int'(r_idx) >= N_REQ) || (rid_m[AXI_ID_W-1:IDX_W] != '0);

  always_comb begin
    req_rvalid = '0;
    rready_m   = 1'b1;
    if (!bad_rid) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (int'(r_idx) == i) begin
          req_rvalid[i] = rvalid_m;
          rready_m      = req_rready[i];
        end
      end
    end
  end

  assign req_rdata = rdata_m;
  assign req_rlast = rlast_m;
  assign r_hs      = rvalid_m && rready_m;
  assign r_done    = r_hs && rlast_m;

  // Per-requester increment/decrement strobes; underflow flags a last beat
  // for a requester that has no burst in flight.
  always_comb begin
    cnt_inc   = req_arready;
    cnt_dec   = '0;
    underflow = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_done && !bad_rid && (int'(r_idx) == i)) begin
        cnt_dec[i] = 1'b1;
        if (out_cnt[i] == '0) underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst)
        out_cnt[i] <= '0;
      else if (cnt_inc[i] && !cnt_dec[i])
        out_cnt[i] <= out_cnt[i] + CNT_W'(1);
      else if (cnt_dec[i] && !cnt_inc[i] && (out_cnt[i] != '0))
        out_cnt[i] <= out_cnt[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if ((r_hs && (bad_rid || (rresp_m != 2'b00))) || underflow)
      err <= 1'b1;
  end

  always_comb begin
    busy = arvalid_m;
    for (int i = 0; i < N_REQ; i++)
      if (out_cnt[i] != '0) busy = 1'b1;
  end

endmodule
